// File: rtl/amba_axi4_pkg.sv
// Shared AXI4 definitions for the write responder slice.
//   resp_t     : AXI response codes carried on BRESP
//   BYTE_WIDTH : bits per WSTRB lane
//   lane_bits  : number of byte-offset address bits for a given data width
package amba_axi4_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int BYTE_WIDTH = 8;

    function automatic int lane_bits(input int data_width);
        return $clog2(data_width / BYTE_WIDTH);
    endfunction

endpackage

// File: rtl/amba_axi4_hold_reg.sv
// One-entry holding buffer for a single AXI channel.
//   clk, rst_n : clock, async active-low reset
//   valid      : channel VALID from the manager
//   ready      : channel READY back to the manager (registered, = !full)
//   payload    : channel payload captured on valid && ready
//   data       : held payload
//   full       : buffer occupied
//   clear      : release the entry (only asserted while full)
module amba_axi4_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] payload,
    output logic [WIDTH-1:0] data,
    output logic             full,
    input  logic             clear
);

    assign ready = !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (valid && !full) begin
            full <= 1'b1;
            data <= payload;
        end
    end

endmodule

// File: rtl/amba_axi4_write_responder.sv
// AXI4 write-only register bank responder.
//   ACLK, ARESETn        : clock, async active-low reset
//   AWVALID/AWREADY/...  : write address channel (AWPROT ignored)
//   WVALID/WREADY/...    : write data channel with byte strobes
//   BVALID/BREADY/BRESP  : write response channel (OKAY or SLVERR)
//   REG_Q                : flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module amba_axi4_write_responder
    import amba_axi4_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           WVALID,
    output logic                           WREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    output logic                           BVALID,
    input  logic                           BREADY,
    output logic [1:0]                     BRESP,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q
);

    localparam int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH;
    localparam int LANE_BITS  = lane_bits(DATA_WIDTH);
    localparam int IDX_BITS   = $clog2(NUM_REGS);

    logic                     aw_full;
    logic                     w_full;
    logic [ADDRESS_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0]    w_data;
    logic [STRB_WIDTH-1:0]    w_strb;
    logic                     commit;
    logic                     wr_ok;
    logic [IDX_BITS-1:0]      idx;
    resp_t                    bresp_q;
    logic                     unused_prot;

    assign unused_prot = ^AWPROT;

    amba_axi4_hold_reg #(.WIDTH(ADDRESS_WIDTH)) u_aw_hold (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .valid   (AWVALID),
        .ready   (AWREADY),
        .payload (AWADDR),
        .data    (aw_addr),
        .full    (aw_full),
        .clear   (commit)
    );

    amba_axi4_hold_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_hold (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .valid   (WVALID),
        .ready   (WREADY),
        .payload ({WSTRB, WDATA}),
        .data    ({w_strb, w_data}),
        .full    (w_full),
        .clear   (commit)
    );

    // A pending response blocks commit, so nothing commits on the B-handshake edge.
    assign commit = aw_full && w_full && !BVALID;

    // Every address bit above the index field must be zero: no aliasing.
    assign idx   = aw_addr[LANE_BITS +: IDX_BITS];
    assign wr_ok = (aw_addr[LANE_BITS-1:0] == '0) &&
                   ((aw_addr >> (LANE_BITS + IDX_BITS)) == '0);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            REG_Q <= '0;
        end else if (commit && wr_ok) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (w_strb[k]) begin
                    REG_Q[int'(idx) * DATA_WIDTH + k * BYTE_WIDTH +: BYTE_WIDTH] <=
                        w_data[k * BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            BVALID  <= 1'b0;
            bresp_q <= OKAY;
        end else if (commit) begin
            BVALID  <= 1'b1;
            bresp_q <= wr_ok ? OKAY : SLVERR;
        end else if (BVALID && BREADY) begin
            BVALID  <= 1'b0;
        end
    end

    assign BRESP = bresp_q;

endmodule

// File: doc/amba_axi4_write_responder.md
AMBA_AXI4_WRITE_RESPONDER -- requirements
Module: amba_axi4_write_responder

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: AWADDR width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: WDATA width in bits; SHALL be 32 or 64.
REQ-003 Parameter NUM_REGS, default 16: number of DATA_WIDTH-bit registers; SHALL be a power of two, at least 2.
REQ-004 One clock; reset is asynchronous and active-low; ports are named ACLK and ARESETn.
REQ-005 ACLK  in  1  clock; all state changes on the rising edge.
REQ-006 ARESETn  in  1  asynchronous active-low reset.
REQ-007 AWVALID  in  1  write-address valid.
REQ-008 AWREADY  out  1  write-address ready.
REQ-009 AWADDR  in  ADDRESS_WIDTH  byte address.
REQ-010 AWPROT  in  3  protection attributes; accepted and ignored.
REQ-011 WVALID  in  1  write-data valid.
REQ-012 WREADY  out  1  write-data ready.
REQ-013 WDATA  in  DATA_WIDTH  write data.
REQ-014 WSTRB  in  DATA_WIDTH/8  byte-lane strobes.
REQ-015 BVALID  out  1  write-response valid.
REQ-016 BREADY  in  1  write-response ready.
REQ-017 BRESP  out  2  response code, OKAY=2'b00, SLVERR=2'b10.
REQ-018 REG_Q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-019 AW and W SHALL each have a one-entry holding buffer with flags aw_full and w_full.
REQ-020 AWREADY SHALL equal !aw_full and WREADY SHALL equal !w_full; neither SHALL depend combinationally on any VALID input.
REQ-021 On AWVALID&&AWREADY at an edge, the block SHALL capture AWADDR and set aw_full; on WVALID&&WREADY it SHALL capture WDATA/WSTRB and set w_full.
REQ-022 AW and W handshakes SHALL be independent: same cycle, AW first, or W first, with no limit on the gap.
REQ-023 Commit SHALL occur at the first edge where aw_full && w_full && !BVALID; both buffers are freed at that same edge.
REQ-024 At commit, BVALID SHALL be set to 1 and BRESP loaded.
REQ-025 Latency: AW and W handshaking together at edge N with BVALID low SHALL give commit, register update and BVALID=1 after edge N+1.
REQ-026 Decode: word index = AWADDR >> log2(DATA_WIDTH/8).
REQ-027 Write condition: low log2(DATA_WIDTH/8) address bits are zero and index < NUM_REGS.
REQ-028 When the write condition holds, each byte lane k with WSTRB[k]=1 SHALL be updated, other lanes kept, and BRESP=OKAY.
REQ-029 Otherwise no register SHALL change and BRESP=SLVERR.
REQ-030 BVALID and BRESP SHALL stay stable until BVALID&&BREADY; BVALID clears at that edge.
REQ-031 No commit SHALL occur at the B-handshake edge; a pending pair commits at the next edge.
REQ-032 While BVALID=1, new AW/W SHALL still be accepted into free buffers; once a buffer is full, its READY stays 0 until commit.
REQ-033 WSTRB=0 with a valid address SHALL return OKAY and leave the register unchanged.
REQ-034 Address bits above the index range SHALL take part in the range check and SHALL NOT be ignored; there is no aliasing.

Reset
REQ-035 ARESETn low SHALL immediately clear aw_full, w_full, BVALID, BRESP and all registers to 0, so AWREADY=WREADY=1 and REG_Q=0.
REQ-036 Reset mid-transaction SHALL discard any buffered AW/W and any pending response, with no register write.
REQ-037 Release SHALL be taken on a clock edge; the first handshake is accepted at the first edge after deassertion.

Structure
REQ-038 Shared package amba_axi4_pkg SHALL hold the resp_t enum (OKAY, EXOKAY, SLVERR, DECERR) and the localparam used for strobe width.
REQ-039 The one-entry buffer SHALL be sub-module amba_axi4_hold_reg (parameter WIDTH; ports valid/ready in, payload, full, clear), instantiated once for AW and once for W.

Verification
REQ-040 AW 0x08 and W 0xDEADBEEF/0xF in the same cycle, BREADY=1 -> BVALID one edge later, BRESP=OKAY, reg2=0xDEADBEEF, BVALID low after one cycle.
REQ-041 W 0x000000AA/0x1 three cycles before AW 0x04 -> WREADY=0 after W accepted; commit one edge after AW; reg1 byte0=0xAA, other bytes unchanged.
REQ-042 AW 0x40 (NUM_REGS=16) with any W -> BRESP=SLVERR, REG_Q unchanged; AW 0x05 -> SLVERR.
REQ-043 BREADY held 0 for 5 cycles while a second AW/W pair arrives -> first BRESP stable; AWREADY=WREADY=0 after the second pair; second commit one edge after the first B handshake.
REQ-044 ARESETn pulsed low between AW acceptance and W -> REG_Q=0, AWREADY=WREADY=1, BVALID=0; a later W alone produces no response.
REQ-045 All scenarios SHALL run with amba_axi4_protocol_checker bound at TYPE=1 and zero assertion failures.
